ascon_dout_capture: RTL and testbench
=====================================

ASCON_DOUT_CAPTURE -- requirements
Module: ascon_dout_capture

Interface
REQ-001 The block SHALL have parameter pWORDS, default 8, the capture buffer depth in 32-bit words (fixed at 8 for this revision).
REQ-002 clk  input  1  crypto clock, the only clock; all logic rising-edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 init  input  1  one-cycle pulse; clears the buffer and status and returns the block to IDLE.
REQ-005 busy  input  1  core busy flag; a 0->1 edge starts a capture window.
REQ-006 val_dout  input  1  output-word strobe from the core.
REQ-007 waddr  input  8  word index of dout.
REQ-008 dout  input  32  output word from the core.
REQ-009 exp_words  input  4  expected distinct word count; sampled on capture start.
REQ-010 rd_idx  input  5  byte index 0..31 for the register-side read.
REQ-011 rd_byte  output  8  registered read byte.
REQ-012 word_mask  output  pWORDS  bit i set when word i has been captured.
REQ-013 done  output  1  high while in COMPLETE.
REQ-014 err  output  1  high while in ERROR.
REQ-015 cyc_count  output  16  crypto cycles spent in CAPTURE, saturating.

Function
REQ-016 The FSM SHALL have four states: IDLE, CAPTURE, COMPLETE and ERROR.
REQ-017 IDLE->CAPTURE occurs on busy=1 with busy_q=0, where busy_q is busy registered one cycle.
- On this edge the block clears word_mask, the distinct count and cyc_count.
- It latches exp_words into exp_q, mapping 0 and 9..15 to 8.
REQ-018 In CAPTURE, val_dout=1 with waddr<pWORDS SHALL store dout into word[waddr] and set word_mask[waddr] at the next edge.
REQ-019 A repeat write to an already-set index SHALL overwrite the data and SHALL NOT increment the distinct count.
REQ-020 In CAPTURE, val_dout=1 with waddr>=pWORDS SHALL cause no buffer write and SHALL move the FSM to ERROR.
REQ-021 CAPTURE->COMPLETE occurs on the edge where the distinct count (including the word being written) reaches exp_q; done rises in that same cycle.
REQ-022 CAPTURE->ERROR occurs when busy falls (busy=0, busy_q=1) while the count is below exp_q.
- If the final required word arrives in the same cycle that busy falls, COMPLETE takes precedence.
REQ-023 cyc_count SHALL increment by 1 on every clock spent in CAPTURE, saturating at 16'hFFFF without wrap-around.
REQ-024 val_dout SHALL be ignored in IDLE, COMPLETE and ERROR.
REQ-025 In COMPLETE or ERROR, a busy 0->1 edge SHALL start a new capture exactly as from IDLE.
REQ-026 init=1 SHALL take priority over every other event in the same cycle.
- Next state is IDLE.
- Buffer, word_mask, done, err and cyc_count are zeroed.
REQ-027 Read port: at each edge rd_byte <= word[rd_idx[4:2]] byte rd_idx[1:0], big-endian (idx 0 = bits 31:24), so the read latency is one cycle.
REQ-028 Reads SHALL be permitted in every state and SHALL reflect all writes completed on earlier edges.

Reset
REQ-029 With rst=0 at a rising edge, the block SHALL enter IDLE with:
- all buffer words = 0, word_mask = 0;
- done = 0, err = 0, cyc_count = 0;
- rd_byte = 0, busy_q = 0, exp_q = 8.
REQ-030 Reset asserted mid-capture SHALL abandon the capture, and no write SHALL occur on that edge.

Verification
REQ-031 Scenario: exp_words=4, busy rises, words 0..3 = 32'h01234567, 89ABCDEF, DEADBEEF, 0BADF00D on consecutive cycles -> word_mask=8'h0F, done=1 in the cycle after the 4th write, cyc_count=4, rd_idx=4 gives 8'h89 one cycle later.
REQ-032 Scenario: exp_words=0, 8 writes with word 3 written twice (second value 32'hCAFEBABE) -> done only after the 8th distinct index, rd_idx=12 gives 8'hCA.
REQ-033 Scenario: exp_words=2, one word written, then busy falls -> err=1, done=0, word_mask=8'h01; a new busy edge restarts with err=0 and word_mask=0.
REQ-034 Scenario: val_dout with waddr=8'h09 during CAPTURE -> err=1, word_mask unchanged, buffer unchanged.
REQ-035 Scenario: init and val_dout asserted in the same cycle in CAPTURE -> IDLE, word_mask=0, all reads return 0; busy held high for 70000 cycles -> cyc_count=16'hFFFF.
REQ-036 Scenario: rst=0 mid-capture after 3 writes -> all outputs at reset values on the next cycle; final word and busy fall in the same cycle -> done=1, err=0.

Source files
------------

// File: rtl/ascon_dout_capture_if.sv
// Bus bundle between an ASCON core's output side and the dout capture buffer.
// The master drives the core strobes and read index; the slave returns status and read data.
interface ascon_dout_capture_if #(
  parameter int pWORDS = 8
);
  logic              init;
  logic              busy;
  logic              val_dout;
  logic [7:0]        waddr;
  logic [31:0]       dout;
  logic [3:0]        exp_words;
  logic [4:0]        rd_idx;
  logic [7:0]        rd_byte;
  logic [pWORDS-1:0] word_mask;
  logic              done;
  logic              err;
  logic [15:0]       cyc_count;

  modport master (
    output init, busy, val_dout, waddr, dout, exp_words, rd_idx,
    input  rd_byte, word_mask, done, err, cyc_count
  );

  modport slave (
    input  init, busy, val_dout, waddr, dout, exp_words, rd_idx,
    output rd_byte, word_mask, done, err, cyc_count
  );
endinterface

// File: rtl/ascon_dout_capture.sv
// Captures output words from an ASCON core into a small buffer during a busy window,
// tracks which indices arrived, and exposes the buffer through a registered byte read port.
module ascon_dout_capture #(
  parameter int pWORDS = 8
) (
  input logic                  clk,
  input logic                  rst,
  ascon_dout_capture_if.slave  bus
);

  localparam int          IW       = $clog2(pWORDS);
  localparam logic [7:0]  WORDS_W8 = 8'(pWORDS);
  localparam logic [3:0]  EXP_MAX  = 4'(pWORDS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    COMPLETE = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       words_q [pWORDS];
  logic [31:0]       words_d [pWORDS];
  logic [pWORDS-1:0] mask_q, mask_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        exp_q, exp_d;
  logic [15:0]       cyc_q, cyc_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        rd_byte_q, rd_byte_d;

  logic              busy_rise_s;
  logic              busy_fall_s;
  logic              addr_ok_s;
  logic [IW-1:0]     widx_s;
  logic [31:0]       rd_word_s;

  // A zero or out-of-range expectation means "wait for the whole buffer".
  function automatic logic [3:0] map_exp(input logic [3:0] e);
    if (e == 4'd0 || e > EXP_MAX) begin
      return EXP_MAX;
    end else begin
      return e;
    end
  endfunction

  assign busy_rise_s = bus.busy & ~busy_q;
  assign busy_fall_s = ~bus.busy & busy_q;
  assign addr_ok_s   = (bus.waddr < WORDS_W8);
  assign widx_s      = bus.waddr[IW-1:0];
  assign rd_word_s   = words_q[bus.rd_idx[4:2]];

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    cyc_d   = cyc_q;

    if (bus.init) begin
      state_d = IDLE;
      words_d = '{default: 32'd0};
      mask_d  = '0;
      cnt_d   = 4'd0;
      cyc_d   = 16'd0;
    end else begin
      case (state_q)
        IDLE, COMPLETE, ERROR: begin
          if (busy_rise_s) begin
            state_d = CAPTURE;
            mask_d  = '0;
            cnt_d   = 4'd0;
            cyc_d   = 16'd0;
            exp_d   = map_exp(bus.exp_words);
          end else begin
            state_d = state_q;
          end
        end
        CAPTURE: begin
          cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
          if (bus.val_dout && !addr_ok_s) begin
            state_d = ERROR;
          end else begin
            if (bus.val_dout) begin
              words_d[widx_s] = bus.dout;
              mask_d[widx_s]  = 1'b1;
              cnt_d           = cnt_q + {3'd0, ~mask_q[widx_s]};
            end else begin
              cnt_d = cnt_q;
            end
            // The arriving word counts toward completion before a busy drop is judged.
            if (cnt_d >= exp_q) begin
              state_d = COMPLETE;
            end else if (busy_fall_s) begin
              state_d = ERROR;
            end else begin
              state_d = CAPTURE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    done_d = (state_d == COMPLETE);
    err_d  = (state_d == ERROR);

    case (bus.rd_idx[1:0])
      2'd0:    rd_byte_d = rd_word_s[31:24];
      2'd1:    rd_byte_d = rd_word_s[23:16];
      2'd2:    rd_byte_d = rd_word_s[15:8];
      2'd3:    rd_byte_d = rd_word_s[7:0];
      default: rd_byte_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      words_q   <= '{default: 32'd0};
      mask_q    <= '0;
      cnt_q     <= 4'd0;
      exp_q     <= EXP_MAX;
      cyc_q     <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_byte_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      words_q   <= words_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      cyc_q     <= cyc_d;
      busy_q    <= bus.busy;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_byte_q <= rd_byte_d;
    end
  end

  assign bus.rd_byte   = rd_byte_q;
  assign bus.word_mask = mask_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.cyc_count = cyc_q;

endmodule

// File: tb/tb_ascon_dout_capture.sv
// Directed bench for ascon_dout_capture: stimulus queues expected snapshots,
// a negedge monitor compares them once the registered read result is presented.
module tb_ascon_dout_capture;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ascon_dout_capture_if #(.pWORDS(8)) bus ();

  ascon_dout_capture #(.pWORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  rbyte;
    logic [7:0]  mask;
    logic        done;
    logic        err;
    logic [15:0] cyc;
    bit          chk_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  logic req_valid = 1'b0;
  logic req_seen  = 1'b0;
  logic end_req   = 1'b0;
  logic end_done  = 1'b0;

  always @(posedge clk) req_seen <= req_valid;

  task automatic cmp(input string nm, input string field, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s.%s got %h want %h", nm, field, got, want);
    end
  endtask

  // Monitor: a read issued before the last edge is now visible on rd_byte and status.
  always @(negedge clk) begin
    if (req_seen) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL monitor got output with empty scoreboard want entry");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        cmp(e.name, "rd_byte", {8'd0, bus.rd_byte}, {8'd0, e.rbyte});
        cmp(e.name, "mask", {8'd0, bus.word_mask}, {8'd0, e.mask});
        cmp(e.name, "done", {15'd0, bus.done}, {15'd0, e.done});
        cmp(e.name, "err", {15'd0, bus.err}, {15'd0, e.err});
        if (e.chk_cyc) cmp(e.name, "cyc", bus.cyc_count, e.cyc);
      end
    end
    if (end_req && !end_done) begin
      tests++;
      if (sb_q.size() != 0) begin
        fails++;
        $display("FAIL drain pending %0d want 0", sb_q.size());
      end
      end_done = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.val_dout = 1'b1;
    bus.waddr    = a;
    bus.dout     = d;
    tick();
    bus.val_dout = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [4:0] idx, input logic [7:0] b, input logic [7:0] m,
                     input logic d, input logic e, input logic [15:0] c, input bit cc);
    exp_t x;
    x.name = nm; x.rbyte = b; x.mask = m; x.done = d; x.err = e; x.cyc = c; x.chk_cyc = cc;
    sb_q.push_back(x);
    bus.rd_idx = idx;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  initial begin
    bus.init = 1'b0; bus.busy = 1'b0; bus.val_dout = 1'b0; bus.waddr = 8'd0;
    bus.dout = 32'd0; bus.exp_words = 4'd0; bus.rd_idx = 5'd0;
    repeat (3) tick();
    rst = 1'b1;
    chk("reset", 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 1'b1);

    // Four-word capture with hand-computed big-endian reads
    bus.exp_words = 4'd4; bus.busy = 1'b1; tick();
    wr(8'd0, 32'h01234567);
    wr(8'd1, 32'h89ABCDEF);
    wr(8'd2, 32'hDEADBEEF);
    wr(8'd3, 32'h0BADF00D);
    chk("s1_idx4", 5'd4, 8'h89, 8'h0F, 1'b1, 1'b0, 16'd4, 1'b1);
    chk("s1_idx11", 5'd11, 8'hEF, 8'h0F, 1'b1, 1'b0, 16'd4, 1'b1);
    chk("s1_idx15", 5'd15, 8'h0D, 8'h0F, 1'b1, 1'b0, 16'd4, 1'b1);
    bus.busy = 1'b0; tick();

    // exp_words=0 waits for all eight; index 3 rewritten
    bus.exp_words = 4'd0; bus.busy = 1'b1; tick();
    wr(8'd0, 32'h10101010);
    wr(8'd1, 32'h11111111);
    wr(8'd2, 32'h12121212);
    wr(8'd3, 32'h13131313);
    wr(8'd3, 32'hCAFEBABE);
    wr(8'd4, 32'h14141414);
    wr(8'd5, 32'h15151515);
    wr(8'd6, 32'h16161616);
    chk("s2_seven", 5'd12, 8'hCA, 8'h7F, 1'b0, 1'b0, 16'd9, 1'b1);
    wr(8'd7, 32'h17171717);
    chk("s2_full", 5'd12, 8'hCA, 8'hFF, 1'b1, 1'b0, 16'd10, 1'b1);
    chk("s2_idx29", 5'd29, 8'h17, 8'hFF, 1'b1, 1'b0, 16'd10, 1'b1);
    bus.busy = 1'b0; tick();

    // Busy falls short of the expected count, then restart
    bus.exp_words = 4'd2; bus.busy = 1'b1; tick();
    wr(8'd0, 32'hA5A50001);
    bus.busy = 1'b0; tick();
    chk("s3_err", 5'd0, 8'hA5, 8'h01, 1'b0, 1'b1, 16'd2, 1'b1);
    bus.busy = 1'b1; tick();
    chk("s3_restart", 5'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 16'd1, 1'b1);

    // Out-of-range waddr=9 must not alias onto word 1
    wr(8'd1, 32'h11223344);
    wr(8'd9, 32'hFFFFFFFF);
    chk("s4_badaddr", 5'd4, 8'h11, 8'h02, 1'b0, 1'b1, 16'd3, 1'b1);
    chk("s4_idx7", 5'd7, 8'h44, 8'h02, 1'b0, 1'b1, 16'd3, 1'b1);
    bus.busy = 1'b0; tick();

    // init beats a simultaneous write
    bus.exp_words = 4'd4; bus.busy = 1'b1; tick();
    wr(8'd0, 32'h77665544);
    bus.init = 1'b1;
    wr(8'd1, 32'h99999999);
    bus.init = 1'b0;
    chk("s5_init0", 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 1'b1);
    chk("s5_init4", 5'd4, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 1'b1);

    // Long capture saturates the cycle counter; exp 12 maps to 8
    bus.busy = 1'b0; tick();
    bus.exp_words = 4'd12; bus.busy = 1'b1; tick();
    repeat (70000) tick();
    chk("s5_sat", 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    bus.busy = 1'b0; tick();
    chk("s5_fall", 5'd0, 8'h00, 8'h00, 1'b0, 1'b1, 16'hFFFF, 1'b1);

    // Reset mid-capture with a write on the reset edge
    bus.exp_words = 4'd4; bus.busy = 1'b1; tick();
    wr(8'd0, 32'hC0DE0000);
    wr(8'd1, 32'hC0DE0001);
    wr(8'd2, 32'hC0DE0002);
    rst = 1'b0; bus.busy = 1'b0;
    wr(8'd3, 32'h12345678);
    rst = 1'b1;
    chk("s6_rst12", 5'd12, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 1'b1);
    chk("s6_rst0", 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 1'b1);

    // Final word lands in the same cycle busy falls
    bus.busy = 1'b1; tick();
    wr(8'd0, 32'hC0DE0000);
    wr(8'd1, 32'hC0DE0001);
    wr(8'd2, 32'hC0DE0002);
    bus.busy = 1'b0;
    wr(8'd3, 32'h55667788);
    chk("s6_race", 5'd13, 8'h66, 8'h0F, 1'b1, 1'b0, 16'd4, 1'b1);

    end_req = 1'b1;
    repeat (3) tick();
    if (!end_done) begin
      $display("FAIL drain monitor did not finish want done");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    end else begin
      $display("[TB] %0d tests run, %0d failed", tests, fails);
    end
    $finish;
  end

endmodule
